vec_alu_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational vector arithmetic unit. Splits LANES x WORD_W operand vectors into lanes and applies one lane-wise op per transaction. Ops: add, sub, unsigned mul, signed mul, and optional saturating add. Sits between the vector register file read port and the writeback stage, with valid/ready handshakes on both sides and a fixed 2-cycle latency.

---
 rtl/vec_alu_pkg.sv | 21 ++
 rtl/vec_alu_pipe_if.sv | 30 +++
 rtl/vec_alu_lane.sv | 53 +++++
 rtl/vec_alu_pipe.sv | 86 ++++++++
 tb/tb_vec_alu_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_alu_pkg.sv
// Shared opcode definitions for the pipelined vector ALU.
// The VEC_ALU_SAT_EN macro makes SADD (101) a legal opcode.
package vec_alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_MULU = 3'b001;
  localparam op_t OP_SUB  = 3'b010;
  localparam op_t OP_MULS = 3'b011;
  localparam op_t OP_SADD = 3'b101;

  function automatic logic is_legal_op(input op_t op);
`ifdef VEC_ALU_SAT_EN
    return op inside {OP_ADD, OP_MULU, OP_SUB, OP_MULS, OP_SADD};
`else
    return op inside {OP_ADD, OP_MULU, OP_SUB, OP_MULS};
`endif
  endfunction

endpackage

// File: rtl/vec_alu_pipe_if.sv
// Operand-side and result-side handshake bundle for vec_alu_pipe.
interface vec_alu_pipe_if
  import vec_alu_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int WORD_W = 32
);
  localparam int VEC_W = LANES * WORD_W;

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [VEC_W-1:0] A;
  logic [VEC_W-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] low_result;
  logic [VEC_W-1:0] high_result;
  logic             op_err;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, low_result, high_result, op_err
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, low_result, high_result, op_err
  );
endinterface

// File: rtl/vec_alu_lane.sv
// Combinational single-lane datapath; 2*WORD_W result split into lo/hi.
// SADD saturation logic exists only when VEC_ALU_SAT_EN is defined.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  op_t               op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] lo,
  output logic [WORD_W-1:0] hi
);
  logic        [2*WORD_W-1:0] au, bu, res;
  logic signed [2*WORD_W-1:0] as_, bs_, prod_s;

  assign au     = {{WORD_W{1'b0}}, a};
  assign bu     = {{WORD_W{1'b0}}, b};
  assign as_    = {{WORD_W{a[WORD_W-1]}}, a};
  assign bs_    = {{WORD_W{b[WORD_W-1]}}, b};
  assign prod_s = as_ * bs_;

`ifdef VEC_ALU_SAT_EN
  logic [WORD_W:0] ssum;
  assign ssum = {a[WORD_W-1], a} + {b[WORD_W-1], b};
`endif

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = au + bu;
      OP_MULU: res = au * bu;
      OP_SUB:  res = {{(WORD_W-1){1'b0}}, (a < b), a - b};
      OP_MULS: res = prod_s;
`ifdef VEC_ALU_SAT_EN
      OP_SADD: begin
        // Sign-extended sum disagreeing in its top two bits means overflow.
        if (ssum[WORD_W] != ssum[WORD_W-1]) begin
          res[WORD_W-1:0] = ssum[WORD_W] ? {1'b1, {(WORD_W-1){1'b0}}}
                                         : {1'b0, {(WORD_W-1){1'b1}}};
          res[WORD_W]     = 1'b1;
        end else begin
          res[WORD_W-1:0] = ssum[WORD_W-1:0];
        end
      end
`endif
      default: res = '0;
    endcase
  end

  assign lo = res[WORD_W-1:0];
  assign hi = res[2*WORD_W-1:WORD_W];
endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage lane-wise vector ALU: S1 captures op/operands, S2 registers results.
// Build with VEC_ALU_SAT_EN defined to enable the saturating add opcode.
module vec_alu_pipe
  import vec_alu_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int WORD_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  vec_alu_pipe_if.slave  io,
  output logic           busy
);
  localparam int STAGES = 2;

  logic [STAGES:1]                 vld_pipe_q, vld_pipe_d;
  op_t                             op_q, op_d;
  logic [LANES-1:0][WORD_W-1:0]    a_q, a_d, b_q, b_d;
  logic [LANES-1:0][WORD_W-1:0]    lo_q, lo_d, hi_q, hi_d;
  logic [LANES-1:0][WORD_W-1:0]    lane_lo, lane_hi;
  logic                            err_q, err_d;
  logic                            advance;

  // A full output stage blocks the whole pipe until downstream takes it.
  assign advance     = !vld_pipe_q[STAGES] || io.out_ready;
  assign io.in_ready = advance;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_alu_lane #(.WORD_W(WORD_W)) u_lane (
      .op (op_q),
      .a  (a_q[i]),
      .b  (b_q[i]),
      .lo (lane_lo[i]),
      .hi (lane_hi[i])
    );
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    err_d      = err_q;
    if (advance) begin
      vld_pipe_d = {vld_pipe_q[1], io.in_valid};
      if (io.in_valid) begin
        op_d = io.op;
        a_d  = io.A;
        b_d  = io.B;
      end
      if (vld_pipe_q[1]) begin
        lo_d  = lane_lo;
        hi_d  = lane_hi;
        err_d = !is_legal_op(op_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      err_q      <= err_d;
    end
  end

  assign io.out_valid   = vld_pipe_q[STAGES];
  assign io.low_result  = lo_q;
  assign io.high_result = hi_q;
  assign io.op_err      = err_q;
  assign busy           = |vld_pipe_q;
endmodule

// File: tb/tb_vec_alu_pipe.sv
// Directed + random bench for vec_alu_pipe: a 16x32 instance and a 4x16 instance
// scoreboarded against an arithmetic reference model.
module tb_vec_alu_pipe;
  import vec_alu_pkg::*;

  localparam int L1 = 16, W1 = 32, V1 = L1 * W1;
  localparam int L2 = 4,  W2 = 16, V2 = L2 * W2;

  typedef struct {
    logic [V1-1:0] lo;
    logic [V1-1:0] hi;
    bit            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy1, busy2;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$], q2[$];
  bit   st1 = 0, st2 = 0, d2_on = 1;
  exp_t h1, h2;

  always #5 clk = ~clk;

  vec_alu_pipe_if #(.LANES(L1), .WORD_W(W1)) i1 ();
  vec_alu_pipe_if #(.LANES(L2), .WORD_W(W2)) i2 ();

  vec_alu_pipe #(.LANES(L1), .WORD_W(W1)) dut1 (
    .clk(clk), .rst_n(rst_n), .io(i1.slave), .busy(busy1));
  vec_alu_pipe #(.LANES(L2), .WORD_W(W2)) dut2 (
    .clk(clk), .rst_n(rst_n), .io(i2.slave), .busy(busy2));

  task automatic chk(input string tag, input logic [V1-1:0] obs, input logic [V1-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference for one lane, straight from the opcode definitions using 64-bit math.
  function automatic void lane_ref(input logic [2:0] op, input longint unsigned a,
                                   input longint unsigned b, input int w,
                                   output longint unsigned lo, output longint unsigned hi,
                                   output bit err);
    longint unsigned m;
    longint sa, sb, r, mx, mn;
    m  = (64'd1 << w) - 64'd1;
    sa = ((a >> (w - 1)) & 64'd1) != 0 ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = ((b >> (w - 1)) & 64'd1) != 0 ? longint'(b) - (longint'(1) << w) : longint'(b);
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    lo = 0; hi = 0; err = 0; r = 0;
    case (op)
      3'd0: begin lo = (a + b) & m; hi = (a + b) >> w; end
      3'd1: begin lo = (a * b) & m; hi = ((a * b) >> w) & m; end
      3'd2: begin lo = (a - b) & m; hi = (a < b) ? 64'd1 : 64'd0; end
      3'd3: begin r = sa * sb; lo = $unsigned(r) & m; hi = ($unsigned(r) >> w) & m; end
`ifdef VEC_ALU_SAT_EN
      3'd5: begin
        r = sa + sb;
        if (r > mx)      begin lo = $unsigned(mx) & m; hi = 1; end
        else if (r < mn) begin lo = $unsigned(mn) & m; hi = 1; end
        else             lo = $unsigned(r) & m;
      end
`endif
      default: err = 1;
    endcase
  endfunction

  function automatic exp_t vec_ref(input logic [2:0] op, input logic [V1-1:0] a,
                                   input logic [V1-1:0] b, input int lanes, input int w);
    exp_t r;
    longint unsigned m, lo, hi;
    bit e;
    m = (64'd1 << w) - 64'd1;
    r.lo = '0; r.hi = '0; r.err = 0;
    for (int i = 0; i < lanes; i++) begin
      lane_ref(op, 64'(a >> (i * w)) & m, 64'(b >> (i * w)) & m, w, lo, hi, e);
      r.lo  = r.lo | (V1'(lo) << (i * w));
      r.hi  = r.hi | (V1'(hi) << (i * w));
      r.err = e;
    end
    return r;
  endfunction

  // Operand vectors biased toward 0, all-ones, min/max signed values.
  function automatic logic [V1-1:0] rvec(input int lanes, input int w);
    logic [V1-1:0] v;
    longint unsigned x, m;
    v = '0;
    m = (64'd1 << w) - 64'd1;
    for (int i = 0; i < lanes; i++) begin
      case ($urandom_range(0, 5))
        0:       x = 0;
        1:       x = m;
        2:       x = 64'd1 << (w - 1);
        3:       x = (64'd1 << (w - 1)) - 64'd1;
        default: x = {$urandom, $urandom};
      endcase
      v = v | (V1'(x & m) << (i * w));
    end
    return v;
  endfunction

  // One clock: drive at negedge, check/scoreboard, then advance to the next negedge.
  task automatic cyc(input bit v, input logic [2:0] o, input logic [V1-1:0] a,
                     input logic [V1-1:0] b, input bit ordy);
    exp_t e;
    i1.in_valid = v; i1.op = o; i1.A = a; i1.B = b; i1.out_ready = ordy;
    if (d2_on) begin
      i2.in_valid  = 1'($urandom_range(0, 1));
      i2.op        = 3'($urandom_range(0, 7));
      i2.A         = V2'(rvec(L2, W2));
      i2.B         = V2'(rvec(L2, W2));
      i2.out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      i2.in_valid = 1'b0; i2.out_ready = 1'b1;
    end
    #1;
    chk("d1_in_ready", i1.in_ready, !i1.out_valid || i1.out_ready);
    chk("d2_in_ready", i2.in_ready, !i2.out_valid || i2.out_ready);
    if (st1) begin
      chk("d1_hold_v",  i1.out_valid, 1);
      chk("d1_hold_lo", i1.low_result, h1.lo);
      chk("d1_hold_hi", i1.high_result, h1.hi);
    end
    if (st2) begin
      chk("d2_hold_v",  i2.out_valid, 1);
      chk("d2_hold_lo", i2.low_result, h2.lo);
    end
    if (i1.out_valid && i1.out_ready) begin
      chk("d1_expected_result", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_lo", i1.low_result, e.lo);
        chk("d1_hi", i1.high_result, e.hi);
        chk("d1_err", i1.op_err, e.err);
      end
    end
    if (i2.out_valid && i2.out_ready) begin
      chk("d2_expected_result", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("d2_lo", i2.low_result, e.lo);
        chk("d2_hi", i2.high_result, e.hi);
        chk("d2_err", i2.op_err, e.err);
      end
    end
    st1 = i1.out_valid && !i1.out_ready;
    h1.lo = i1.low_result; h1.hi = i1.high_result;
    st2 = i2.out_valid && !i2.out_ready;
    h2.lo = V1'(i2.low_result);
    if (i1.in_valid && i1.in_ready) q1.push_back(vec_ref(i1.op, i1.A, i1.B, L1, W1));
    if (i2.in_valid && i2.in_ready) q2.push_back(vec_ref(i2.op, V1'(i2.A), V1'(i2.B), L2, W2));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, OP_ADD, '0, '0, 1);
  endtask

  // Single op through an empty pipe; lane 0 checked against hand-derived constants.
  task automatic directed(input string tag, input logic [2:0] o, input logic [31:0] a0,
                          input logic [31:0] b0, input logic [31:0] lo0,
                          input logic [31:0] hi0, input bit err);
    logic [V1-1:0] a, b;
    a = rvec(L1, W1); b = rvec(L1, W1);
    a[31:0] = a0; b[31:0] = b0;
    cyc(1, o, a, b, 1);
    idle();
    chk({tag, "_valid"}, i1.out_valid, 1);
    chk({tag, "_lo0"}, i1.low_result[31:0], lo0);
    chk({tag, "_hi0"}, i1.high_result[31:0], hi0);
    chk({tag, "_err"}, i1.op_err, err);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid1"}, i1.out_valid, 0);
    chk({tag, "_busy1"}, busy1, 0);
    chk({tag, "_err1"}, i1.op_err, 0);
    chk({tag, "_lo1"}, i1.low_result, '0);
    chk({tag, "_hi1"}, i1.high_result, '0);
    chk({tag, "_ready1"}, i1.in_ready, 1);
    chk({tag, "_valid2"}, i2.out_valid, 0);
    chk({tag, "_busy2"}, busy2, 0);
  endtask

  initial begin
    logic [V1-1:0] a, b;
    i1.in_valid = 0; i1.op = OP_ADD; i1.A = '0; i1.B = '0; i1.out_ready = 1;
    i2.in_valid = 0; i2.op = OP_ADD; i2.A = '0; i2.B = '0; i2.out_ready = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_checks("rst");
    @(negedge clk);

    // Latency: accepted in cycle 0, out_valid in cycle 2.
    a = '0; b = '0; a[31:0] = 32'hFFFF_FFFF; b[31:0] = 32'h1;
    cyc(1, OP_ADD, a, b, 1);
    chk("lat_c1_valid", i1.out_valid, 0);
    chk("lat_c1_busy", busy1, 1);
    idle();
    chk("lat_c2_valid", i1.out_valid, 1);
    chk("add_lo0", i1.low_result[31:0], 32'h0);
    chk("add_hi0", i1.high_result[31:0], 32'h1);
    chk("add_err", i1.op_err, 0);

    directed("mulu", OP_MULU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'h1, 0);
    directed("muls", OP_MULS, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    directed("sub_brw", OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'h1, 0);
    directed("sub_nob", OP_SUB, 32'd5, 32'd3, 32'h2, 32'h0, 0);
    directed("illegal", 3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 1);
    chk("illegal_all_lo", i1.low_result, '0);
    chk("illegal_all_hi", i1.high_result, '0);
`ifdef VEC_ALU_SAT_EN
    directed("sadd", OP_SADD, 32'h7FFF_FFFF, 32'h1, 32'h7FFF_FFFF, 32'h1, 0);
`else
    directed("sadd_off", OP_SADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 1);
`endif
    repeat (2) idle();

    // Backpressure: 4 back-to-back ops, then 3 stalled cycles offering a 5th.
    for (int i = 0; i < 4; i++)
      cyc(1, 3'($urandom_range(0, 3)), rvec(L1, W1), rvec(L1, W1), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, OP_ADD, rvec(L1, W1), rvec(L1, W1), 0);
      chk("bp_in_ready", i1.in_ready, 0);
      chk("bp_busy", busy1, 1);
    end
    repeat (6) idle();
    chk("bp_drained", q1.size(), 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
          rvec(L1, W1), rvec(L1, W1), 1'($urandom_range(0, 3) != 0));
    repeat (4) idle();

    // Async reset between edges with two ops in flight.
    cyc(1, OP_ADD, rvec(L1, W1), rvec(L1, W1), 1);
    cyc(1, OP_MULU, rvec(L1, W1), rvec(L1, W1), 1);
    chk("mid_busy_pre", busy1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    q1.delete(); q2.delete(); st1 = 0; st2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("post_rst_no_out", i1.out_valid, 0);
    end

    d2_on = 0;
    repeat (8) idle();
    chk("end_q1_empty", q1.size(), 0);
    chk("end_q2_empty", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
